// File: rtl/id_stage_hs_if.sv
// Bus grouping the IF->ID beat handshake and the registered ID->EXE pipe fields.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface id_stage_hs_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int PC_W       = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instruction;
  logic [PC_W-1:0]       pc;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wb_en;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  b;
  logic                  s;
  logic                  imm;
  logic                  carry;
  logic [3:0]            exe_cmd;
  logic [PC_W-1:0]       pc_out;
  logic [DATA_W-1:0]     val_rn;
  logic [DATA_W-1:0]     val_rm;
  logic [11:0]           shift_operand;
  logic [23:0]           signed_imm_24;
  logic [REG_ADDR_W-1:0] dest;
  logic [REG_ADDR_W-1:0] src1_out;
  logic [REG_ADDR_W-1:0] src2_out;

  modport slave (
    input  in_valid, instruction, pc, out_ready,
    output in_ready, out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm, carry,
           exe_cmd, pc_out, val_rn, val_rm, shift_operand, signed_imm_24,
           dest, src1_out, src2_out
  );

  modport master (
    output in_valid, instruction, pc, out_ready,
    input  in_ready, out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm, carry,
           exe_cmd, pc_out, val_rn, val_rm, shift_operand, signed_imm_24,
           dest, src1_out, src2_out
  );
endinterface

// File: rtl/id_stage_hs.sv
// ARM decode stage with valid/ready handshake, register file and condition check.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data to the read ports.
module id_stage_hs #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 4,
  parameter int PC_W         = 32,
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  id_stage_hs_if.slave            bus,
  input  logic                    wb_we,
  input  logic [REG_ADDR_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0]       wb_result,
  input  logic                    hazard,
  input  logic                    flush,
  input  logic [3:0]              sr,
  output logic [REG_ADDR_W-1:0]   src1,
  output logic [REG_ADDR_W-1:0]   src2,
  output logic                    two_src,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);
  localparam int NREGS = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  b;
    logic                  s;
    logic                  imm;
    logic                  carry;
    logic [3:0]            exe_cmd;
    logic [PC_W-1:0]       pc;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
  } pipe_t;

  function automatic pipe_t clear_ctrl(input pipe_t p);
    pipe_t r;
    r          = p;
    r.wb_en    = 1'b0;
    r.mem_r_en = 1'b0;
    r.mem_w_en = 1'b0;
    r.b        = 1'b0;
    r.s        = 1'b0;
    r.imm      = 1'b0;
    r.carry    = 1'b0;
    return r;
  endfunction

  // ARM condition field against {N,Z,C,V}; 1111 never executes
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = cy;
      4'b0011: cond_ok = !cy;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = cy && !z;
      4'b1001: cond_ok = !cy || z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = !z && (n == v);
      4'b1101: cond_ok = z || (n != v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction

  logic [DATA_W-1:0]       rf_q [NREGS];
  logic [DATA_W-1:0]       rf_d [NREGS];
  pipe_t                   pipe_q, pipe_d, dec;
  logic                    out_valid_q, out_valid_d;
  logic [BUBBLE_CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic [1:0]              mode;
  logic                    s_bit, is_store;
  logic [DATA_W-1:0]       rd1, rd2;

  assign mode     = bus.instruction[27:26];
  assign s_bit    = bus.instruction[20];
  assign is_store = (mode == 2'b01) && !s_bit;
  assign src1     = bus.instruction[19:16];
  assign src2     = is_store ? bus.instruction[15:12] : bus.instruction[3:0];
  assign two_src  = !bus.instruction[25] || is_store;

`ifdef ID_WB_BYPASS_EN
  assign rd1 = (wb_we && wb_dest == src1) ? wb_result : rf_q[src1];
  assign rd2 = (wb_we && wb_dest == src2) ? wb_result : rf_q[src2];
`else
  assign rd1 = rf_q[src1];
  assign rd2 = rf_q[src2];
`endif

  always_comb begin
    rf_d = rf_q;
    if (wb_we) rf_d[wb_dest] = wb_result;
  end

  always_comb begin
    dec               = '0;
    dec.pc            = bus.pc;
    dec.val_rn        = rd1;
    dec.val_rm        = rd2;
    dec.shift_operand = bus.instruction[11:0];
    dec.signed_imm_24 = bus.instruction[23:0];
    dec.dest          = bus.instruction[15:12];
    dec.src1          = src1;
    dec.src2          = src2;
    case (mode)
      2'b00: begin
        dec.s     = s_bit;
        dec.imm   = bus.instruction[25];
        dec.carry = sr[1];
        dec.wb_en = 1'b1;
        case (bus.instruction[24:21])
          4'b1101: dec.exe_cmd = 4'b0001;
          4'b1111: dec.exe_cmd = 4'b1001;
          4'b0100: dec.exe_cmd = 4'b0010;
          4'b0101: dec.exe_cmd = 4'b0011;
          4'b0010: dec.exe_cmd = 4'b0100;
          4'b0110: dec.exe_cmd = 4'b0101;
          4'b0000: dec.exe_cmd = 4'b0110;
          4'b1100: dec.exe_cmd = 4'b0111;
          4'b0001: dec.exe_cmd = 4'b1000;
          4'b1010: begin dec.exe_cmd = 4'b0100; dec.wb_en = 1'b0; end
          4'b1000: begin dec.exe_cmd = 4'b0110; dec.wb_en = 1'b0; end
          default: begin dec.exe_cmd = 4'b0000; dec = clear_ctrl(dec); end
        endcase
      end
      2'b01: begin
        dec.exe_cmd  = 4'b0010;
        dec.imm      = bus.instruction[25];
        dec.carry    = sr[1];
        dec.wb_en    = s_bit;
        dec.mem_r_en = s_bit;
        dec.mem_w_en = !s_bit;
      end
      2'b10: dec.b = 1'b1;
      default: ;
    endcase
  end

  // Priority: flush, stalled output, hazard bubble, new beat, drain
  always_comb begin
    pipe_d         = pipe_q;
    out_valid_d    = out_valid_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      out_valid_d = 1'b0;
      pipe_d      = clear_ctrl(pipe_q);
    end else if (out_valid_q && !bus.out_ready) begin
      pipe_d = pipe_q;
    end else if (hazard) begin
      out_valid_d = 1'b1;
      pipe_d      = clear_ctrl(pipe_q);
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + BUBBLE_CNT_W'(1);
    end else if (bus.in_valid) begin
      out_valid_d = 1'b1;
      pipe_d      = cond_ok(bus.instruction[31:28], sr) ? dec : clear_ctrl(dec);
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q         <= '0;
      out_valid_q    <= 1'b0;
      bubble_count_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pipe_q         <= pipe_d;
      out_valid_q    <= out_valid_d;
      bubble_count_q <= bubble_count_d;
      rf_q           <= rf_d;
    end
  end

  assign bus.in_ready      = flush || (!hazard && (!out_valid_q || bus.out_ready));
  assign bus.out_valid     = out_valid_q;
  assign bus.wb_en         = pipe_q.wb_en;
  assign bus.mem_r_en      = pipe_q.mem_r_en;
  assign bus.mem_w_en      = pipe_q.mem_w_en;
  assign bus.b             = pipe_q.b;
  assign bus.s             = pipe_q.s;
  assign bus.imm           = pipe_q.imm;
  assign bus.carry         = pipe_q.carry;
  assign bus.exe_cmd       = pipe_q.exe_cmd;
  assign bus.pc_out        = pipe_q.pc;
  assign bus.val_rn        = pipe_q.val_rn;
  assign bus.val_rm        = pipe_q.val_rm;
  assign bus.shift_operand = pipe_q.shift_operand;
  assign bus.signed_imm_24 = pipe_q.signed_imm_24;
  assign bus.dest          = pipe_q.dest;
  assign bus.src1_out      = pipe_q.src1;
  assign bus.src2_out      = pipe_q.src2;
  assign bubble_count      = bubble_count_q;
endmodule
